// File: rtl/branch_pkg.sv
// Shared branch definitions: 2-bit predictor counter states,
// counter alloc/reset values and conditional-branch funct3 codes.
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_ALLOC = WT;
  localparam ctr_e CTR_RESET = WNT;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// 2-bit saturating counter next-state function.
// Ports: ctr_i current state, taken_i outcome, ctr_o next state.
module sat_counter2
  import branch_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  output ctr_e ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (ctr_i)
      SNT: ctr_o = taken_i ? WNT : SNT;
      WNT: ctr_o = taken_i ? WT  : SNT;
      WT:  ctr_o = taken_i ? ST  : WNT;
      ST:  ctr_o = taken_i ? ST  : WT;
      default: ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters,
// decode-stage resolution -> redirect/flush, branch statistics.
// Ports: if_pc -> pred_taken/pred_target; id_* resolution inputs ->
// redirect/redirect_pc/flush_ifid; branch_cnt/mispred_cnt counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            id_valid,
  input  logic            id_branch,
  input  logic            id_taken,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_target,
  input  logic            id_pred_taken,
  input  logic [XLEN-1:0] id_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_ifid,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int N    = 1 << IDX_BITS;
  localparam int TAGW = XLEN - IDX_BITS - 2;

  logic            valid_q [N];
  logic [TAGW-1:0] tag_q   [N];
  logic [XLEN-1:0] tgt_q   [N];
  ctr_e            ctr_q   [N];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAGW-1:0]     f_tag, u_tag;
  logic                f_hit, u_hit;
  logic                res, mispred;
  ctr_e                ctr_nxt;

  assign f_idx = if_pc[IDX_BITS+1:2];
  assign f_tag = if_pc[XLEN-1:IDX_BITS+2];
  assign u_idx = id_pc[IDX_BITS+1:2];
  assign u_tag = id_pc[XLEN-1:IDX_BITS+2];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Fetch lookup reads registered state only; no bypass of a
  // same-cycle update.
  assign pred_taken  = rst_n && f_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? tgt_q[f_idx]
                                  : if_pc + XLEN'(4);

  assign res = id_valid && id_branch;

  // A taken/taken pair still mispredicts if fetch went elsewhere.
  assign mispred = res &&
    ((id_taken != id_pred_taken) ||
     (id_taken && id_pred_taken && (id_target != id_pred_target)));

  assign redirect    = rst_n && mispred;
  assign flush_ifid  = redirect;
  assign redirect_pc = !redirect ? '0
                     : id_taken  ? id_target
                     : id_pc + XLEN'(4);

  sat_counter2 u_ctr (
    .ctr_i   (ctr_q[u_idx]),
    .taken_i (id_taken),
    .ctr_o   (ctr_nxt)
  );

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res)     branch_cnt_d  = branch_cnt_q + 32'd1;
    if (mispred) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_RESET;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (res) begin
        if (u_hit) begin
          ctr_q[u_idx] <= ctr_nxt;
          if (id_taken) tgt_q[u_idx] <= id_target;
        end else if (id_taken) begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
          tgt_q[u_idx]   <= id_target;
          ctr_q[u_idx]   <= CTR_ALLOC;
        end
      end
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed scenarios plus
// random traffic against an array-based reference predictor.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_valid, id_branch, id_taken;
  logic [31:0] id_pc, id_target;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_ifid;
  logic [31:0] branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .id_valid       (id_valid),
    .id_branch      (id_branch),
    .id_taken       (id_taken),
    .id_pc          (id_pc),
    .id_target      (id_target),
    .id_pred_taken  (id_pred_taken),
    .id_pred_target (id_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush_ifid     (flush_ifid),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];

  // Reference BTB: 16 entries, index = (pc/4)%16, tag = pc/64.
  bit          m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  logic [31:0] m_bc, m_mc;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_bc = '0; m_mc = '0;
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    int i = int'((pc / 4) % 16);
    return m_v[i] && (m_tag[i] == pc / 64);
  endfunction

  task automatic m_pred(input logic [31:0] pc, output logic pt,
                        output logic [31:0] ptg);
    int i = int'((pc / 4) % 16);
    pt  = m_hit(pc) && (m_ctr[i] >= 2);
    ptg = pt ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic step(input logic [31:0] ipc, input logic v, b, t,
                      input logic [31:0] pc, tg,
                      input logic pt, input logic [31:0] ptg);
    exp_t e;
    bit res, mis, hit;
    int i;
    @(posedge clk); #1;
    if_pc = ipc; id_valid = v; id_branch = b; id_taken = t;
    id_pc = pc; id_target = tg;
    id_pred_taken = pt; id_pred_target = ptg;
    m_pred(ipc, e.pt, e.ptgt);
    res = v && b;
    mis = res && ((t != pt) || (t && pt && tg != ptg));
    e.rd  = mis;
    e.rpc = !mis ? 32'd0 : t ? tg : pc + 32'd4;
    e.bc  = m_bc;
    e.mc  = m_mc;
    q.push_back(e);
    if (res) begin
      i = int'((pc / 4) % 16);
      hit = m_hit(pc);
      if (hit) begin
        m_ctr[i] = t ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                     : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (t) m_tgt[i] = tg;
      end else if (t) begin
        m_v[i] = 1; m_tag[i] = pc / 64; m_tgt[i] = tg; m_ctr[i] = 2;
      end
      m_bc = m_bc + 32'd1;
      if (mis) m_mc = m_mc + 32'd1;
    end
  endtask

  task automatic fetch(input logic [31:0] ipc);
    step(ipc, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  function automatic logic [31:0] rnd_pc();
    return 32'h100 + ($urandom_range(0, 3) << 6)
                   + ($urandom_range(0, 15) << 2);
  endfunction

  // Monitor: outputs are valid every cycle once stimulus is applied.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e.pt});
        chk("pred_target", pred_target, e.ptgt);
        chk("redirect",    {31'd0, redirect}, {31'd0, e.rd});
        chk("flush_ifid",  {31'd0, flush_ifid}, {31'd0, e.rd});
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("branch_cnt",  branch_cnt, e.bc);
        chk("mispred_cnt", mispred_cnt, e.mc);
      end
    end
  end

  task automatic check_in_reset(input string tag);
    chk({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush_ifid}, 32'd0);
    chk({tag, "_rpc"}, redirect_pc, 32'd0);
    chk({tag, "_ptaken"}, {31'd0, pred_taken}, 32'd0);
    chk({tag, "_ptgt"}, pred_target, if_pc + 32'd4);
    chk({tag, "_bcnt"}, branch_cnt, 32'd0);
    chk({tag, "_mcnt"}, mispred_cnt, 32'd0);
  endtask

  initial begin
    logic        pt, t, v, b;
    logic [31:0] ptg, pc, tg;
    rst_n = 1'b0;
    if_pc = 32'h100;
    id_valid = 1'b1; id_branch = 1'b1; id_taken = 1'b1;
    id_pc = 32'h100; id_target = 32'h80;
    id_pred_taken = 1'b0; id_pred_target = 32'h104;
    model_reset();
    #3;
    check_in_reset("rst0");
    id_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    fetch(32'h100);
    step(32'h0, 1, 1, 1, 32'h100, 32'h80, 0, 32'h104);
    fetch(32'h100);
    step(32'h100, 1, 1, 0, 32'h100, 32'h80, 1, 32'h80);
    step(32'h100, 1, 1, 0, 32'h100, 32'h80, 0, 32'h104);
    fetch(32'h100);
    step(32'h100, 1, 1, 1, 32'h140, 32'h200, 0, 32'h144);
    fetch(32'h100);
    fetch(32'h140);
    step(32'h140, 1, 1, 1, 32'h140, 32'h200, 1, 32'h200);
    step(32'h140, 1, 1, 1, 32'h140, 32'h210, 1, 32'h200);
    fetch(32'h140);
    step(32'h140, 1, 0, 1, 32'h140, 32'h300, 0, 32'h144);
    step(32'h140, 0, 1, 0, 32'h140, 32'h300, 1, 32'h210);

    @(posedge clk); #1;
    if_pc = 32'h140;
    id_valid = 1'b1; id_branch = 1'b1; id_taken = 1'b1;
    id_pc = 32'h100; id_target = 32'h80;
    id_pred_taken = 1'b0; id_pred_target = 32'h104;
    #1 rst_n = 1'b0;
    #1 check_in_reset("rst1");
    id_valid = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    fetch(32'h140);
    fetch(32'h100);

    for (int n = 0; n < 400; n++) begin
      pc = rnd_pc();
      tg = {$urandom_range(0, 255), 2'b00};
      t  = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 9) != 0);
      b  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) m_pred(pc, pt, ptg);
      else begin
        pt  = 1'($urandom_range(0, 1));
        ptg = pt ? {$urandom_range(0, 255), 2'b00} : pc + 32'd4;
      end
      step(rnd_pc(), v, b, t, pc, tg, pt, ptg);
    end

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
